eth_header_capture: RTL and testbench

//   Byte-stream front end for the L2 parser. Accumulates the first HDR_BYTES bytes of each frame.

---
 rtl/eth_header_capture_if.sv | 35 +++
 rtl/eth_header_capture.sv | 142 ++++++++++++++
 tb/tb_eth_header_capture.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_header_capture_if.sv
// Byte-stream / header-field bundle for eth_header_capture.
//   Input stream  : in_valid, in_data, in_last, in_ready
//   Header fields : header_bytes ([0] = first byte on wire), ethertype_raw, fields_valid, fields_ack
//   Payload stream: out_valid, out_data, out_last, out_ready
//   Status        : runt_err
// slave  = the capture block itself; master = the surrounding environment.
interface eth_header_capture_if #(
    parameter int unsigned HDR_BYTES = 18
);
    logic                           in_valid;
    logic [7:0]                     in_data;
    logic                           in_last;
    logic                           in_ready;
    logic [HDR_BYTES-1:0][7:0]      header_bytes;
    logic [15:0]                    ethertype_raw;
    logic                           fields_valid;
    logic                           fields_ack;
    logic                           out_valid;
    logic [7:0]                     out_data;
    logic                           out_last;
    logic                           out_ready;
    logic                           runt_err;

    modport slave (
        input  in_valid, in_data, in_last, fields_ack, out_ready,
        output in_ready, header_bytes, ethertype_raw, fields_valid,
               out_valid, out_data, out_last, runt_err
    );

    modport master (
        output in_valid, in_data, in_last, fields_ack, out_ready,
        input  in_ready, header_bytes, ethertype_raw, fields_valid,
               out_valid, out_data, out_last, runt_err
    );
endinterface

// File: rtl/eth_header_capture.sv
// Front end of the L2 parser: captures the first HDR_BYTES bytes of each frame,
// presents them to the header consumer until acknowledged, then passes the rest
// of the frame through unchanged. Frames shorter than MIN_HDR are dropped and
// flagged with a one-cycle runt_err pulse.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : eth_header_capture_if.slave (input stream, header fields, payload stream, runt_err)
module eth_header_capture #(
    parameter int unsigned HDR_BYTES = 18,
    parameter int unsigned MIN_HDR   = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    eth_header_capture_if.slave   bus
);

    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HDR_BYTES - 1);

    typedef enum logic [1:0] {
        S_CAPTURE = 2'd0,
        S_HOLD    = 2'd1,
        S_DRAIN   = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [HDR_BYTES-1:0][7:0] hdr_q, hdr_d;
    logic                     drain_pending_q, drain_pending_d;
    logic                     fields_valid_q, fields_valid_d;
    logic                     runt_err_q, runt_err_d;
    logic                     ready_en_q, ready_en_d;

    logic                     in_ready_c;
    logic                     out_valid_c;
    logic                     out_last_c;

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_CAPTURE;
            byte_cnt_q      <= '0;
            hdr_q           <= '0;
            drain_pending_q <= 1'b0;
            fields_valid_q  <= 1'b0;
            runt_err_q      <= 1'b0;
            ready_en_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            byte_cnt_q      <= byte_cnt_d;
            hdr_q           <= hdr_d;
            drain_pending_q <= drain_pending_d;
            fields_valid_q  <= fields_valid_d;
            runt_err_q      <= runt_err_d;
            ready_en_q      <= ready_en_d;
        end
    end

    // Next-state, capture datapath and stream handshakes
    always_comb begin
        state_d         = state_q;
        byte_cnt_d      = byte_cnt_q;
        hdr_d           = hdr_q;
        drain_pending_d = drain_pending_q;
        fields_valid_d  = 1'b0;
        runt_err_d      = 1'b0;
        ready_en_d      = 1'b1;
        in_ready_c      = 1'b0;
        out_valid_c     = 1'b0;
        out_last_c      = 1'b0;

        unique case (state_q)
            S_CAPTURE: begin
                // Held low for the first cycle out of reset.
                in_ready_c = ready_en_q;
                if (bus.in_valid && in_ready_c) begin
                    hdr_d[byte_cnt_q] = bus.in_data;
                    byte_cnt_d        = byte_cnt_q + CNT_W'(1);
                    if (bus.in_last) begin
                        if ((byte_cnt_q + CNT_W'(1)) < CNT_W'(MIN_HDR)) begin
                            runt_err_d = 1'b1;
                            byte_cnt_d = '0;
                            hdr_d      = '0;
                        end else begin
                            // Short but legal header: bytes never written read as zero.
                            for (int unsigned i = 0; i < HDR_BYTES; i++) begin
                                if (CNT_W'(i) > byte_cnt_q) begin
                                    hdr_d[i] = 8'h00;
                                end
                            end
                            state_d         = S_HOLD;
                            fields_valid_d  = 1'b1;
                            drain_pending_d = 1'b0;
                        end
                    end else if (byte_cnt_q == LAST_IDX) begin
                        state_d         = S_HOLD;
                        fields_valid_d  = 1'b1;
                        drain_pending_d = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                fields_valid_d = 1'b1;
                // fields_valid_q is always high in HOLD, so an ack here is never stale.
                if (bus.fields_ack) begin
                    fields_valid_d = 1'b0;
                    if (drain_pending_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d    = S_CAPTURE;
                        byte_cnt_d = '0;
                    end
                end
            end

            S_DRAIN: begin
                out_valid_c = bus.in_valid;
                out_last_c  = bus.in_last;
                in_ready_c  = bus.out_ready;
                if (bus.in_valid && bus.out_ready && bus.in_last) begin
                    state_d    = S_CAPTURE;
                    byte_cnt_d = '0;
                end
            end

            default: begin
                state_d    = S_CAPTURE;
                byte_cnt_d = '0;
            end
        endcase
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.header_bytes  = hdr_q;
    assign bus.ethertype_raw = {hdr_q[12], hdr_q[13]};
    assign bus.fields_valid  = fields_valid_q;
    assign bus.runt_err      = runt_err_q;
    assign bus.out_valid     = out_valid_c;
    assign bus.out_data      = bus.in_data;
    assign bus.out_last      = out_last_c;

endmodule

// File: tb/tb_eth_header_capture.sv
// Bench for eth_header_capture: frame-level reference model (expected header /
// runt events and expected payload bytes queued per frame) checked every cycle.
module tb_eth_header_capture;

    localparam int unsigned HDR_BYTES = 18;
    localparam int unsigned HW        = HDR_BYTES * 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    eth_header_capture_if #(.HDR_BYTES(HDR_BYTES)) bus ();

    eth_header_capture #(.HDR_BYTES(HDR_BYTES), .MIN_HDR(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit            runt;
        logic [HW-1:0] hdr;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } pb_t;

    ev_t ev_q[$];
    pb_t pay_q[$];
    logic [7:0] tx[$];

    int n_tests = 0;
    int n_fail  = 0;
    int ack_delay = 0;
    bit ack_always = 1'b0;
    bit toggle_ready = 1'b0;
    int pay_seen = 0;
    int runt_seen = 0;
    int hdr_seen = 0;
    logic [HW-1:0] last_hdr = '0;
    logic [HW-1:0] dut_hdr;

    assign dut_hdr = bus.header_bytes;

    task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Consumer ack: presented once fields_valid has been seen ack_delay cycles.
    initial begin : ack_proc
        int hold;
        hold = 0;
        bus.fields_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.fields_valid) begin
                bus.fields_ack = (hold >= ack_delay);
                hold++;
            end else begin
                hold = 0;
                bus.fields_ack = ack_always;
            end
        end
    end

    // Payload consumer readiness.
    initial begin : rdy_proc
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = toggle_ready ? ~bus.out_ready : 1'b1;
        end
    end

    // Per-cycle compare against the frame model.
    initial begin : cmp_proc
        bit fv_prev, rt_prev;
        int run;
        ev_t e;
        pb_t p;
        fv_prev = 1'b0;
        rt_prev = 1'b0;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fv_prev = 1'b0;
                rt_prev = 1'b0;
                run = 0;
            end else begin
                if (bus.fields_valid) begin
                    if (!fv_prev) begin
                        run = 0;
                        if (ev_q.size() == 0) begin
                            flag("unexpected_header");
                        end else begin
                            e = ev_q.pop_front();
                            check("hdr_kind", HW'(e.runt), HW'(0));
                            check("header_bytes", dut_hdr, e.hdr);
                            check("ethertype_raw", HW'(bus.ethertype_raw),
                                  HW'({e.hdr[12*8 +: 8], e.hdr[13*8 +: 8]}));
                            hdr_seen++;
                        end
                        last_hdr = dut_hdr;
                    end else begin
                        check("hdr_stable", dut_hdr, last_hdr);
                    end
                    run++;
                    check("in_ready_in_hold", HW'(bus.in_ready), HW'(0));
                    check("out_valid_in_hold", HW'(bus.out_valid), HW'(0));
                end else if (fv_prev) begin
                    check("valid_cycles", HW'(run), HW'(ack_delay + 1));
                end

                if (bus.runt_err) begin
                    check("runt_single_pulse", HW'(rt_prev), HW'(0));
                    check("runt_no_fields", HW'(bus.fields_valid), HW'(0));
                    if (ev_q.size() == 0) begin
                        flag("unexpected_runt");
                    end else begin
                        e = ev_q.pop_front();
                        check("runt_kind", HW'(e.runt), HW'(1));
                    end
                    runt_seen++;
                end

                if (bus.out_valid && bus.out_ready) begin
                    if (pay_q.size() == 0) begin
                        flag("unexpected_payload");
                    end else begin
                        p = pay_q.pop_front();
                        check("out_data", HW'(bus.out_data), HW'(p.data));
                        check("out_last", HW'(bus.out_last), HW'(p.last));
                    end
                    pay_seen++;
                end

                fv_prev = bus.fields_valid;
                rt_prev = bus.runt_err;
            end
        end
    end

    task automatic build_frame(input int len, input logic [15:0] etype, input logic [7:0] seed);
        tx.delete();
        for (int i = 0; i < len; i++) tx.push_back(8'(int'(seed) + i * 7));
        if (len > 13) begin
            tx[12] = etype[15:8];
            tx[13] = etype[7:0];
        end
    endtask

    task automatic drive_byte(input logic [7:0] d, input bit last);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            guard++;
            if (guard > 300) begin
                flag("in_ready_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Sends tx; n_send < size means an unfinished frame that the model never sees.
    task automatic send_frame(input int n_send);
        ev_t e;
        pb_t p;
        int len;
        len = tx.size();
        if (n_send == len) begin
            e.runt = (len < 14);
            e.hdr  = '0;
            for (int i = 0; i < int'(HDR_BYTES) && i < len; i++) e.hdr[i*8 +: 8] = tx[i];
            ev_q.push_back(e);
            for (int i = int'(HDR_BYTES); i < len; i++) begin
                p.data = tx[i];
                p.last = (i == len - 1);
                pay_q.push_back(p);
            end
        end
        for (int i = 0; i < n_send; i++) drive_byte(tx[i], (i == len - 1));
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((ev_q.size() != 0 || pay_q.size() != 0 || bus.fields_valid) && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) flag("idle_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},     HW'(bus.in_ready),     HW'(0));
        check({tag, "_fields_valid"}, HW'(bus.fields_valid), HW'(0));
        check({tag, "_out_valid"},    HW'(bus.out_valid),    HW'(0));
        check({tag, "_runt_err"},     HW'(bus.runt_err),     HW'(0));
        check({tag, "_header"},       dut_hdr,               HW'(0));
    endtask

    initial begin : main
        int p0, r0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("in_ready_pre_edge", HW'(bus.in_ready), HW'(0));
        @(posedge clk);
        #1;
        check("in_ready_after_reset", HW'(bus.in_ready), HW'(1));

        // 1: 64-byte untagged frame, ack together with valid.
        ack_delay = 0;
        p0 = pay_seen;
        build_frame(64, 16'h0800, 8'h03);
        send_frame(64);
        wait_idle();
        check("t1_payload_count", HW'(pay_seen - p0), HW'(46));
        check("t1_ethertype", HW'({last_hdr[12*8 +: 8], last_hdr[13*8 +: 8]}), HW'(16'h0800));

        // 2: VLAN-tagged frame, tag bytes captured as sent.
        build_frame(64, 16'h8100, 8'h11);
        tx[14] = 8'h00; tx[15] = 8'h64; tx[16] = 8'h08; tx[17] = 8'h00;
        send_frame(64);
        wait_idle();
        check("t2_ethertype", HW'({last_hdr[12*8 +: 8], last_hdr[13*8 +: 8]}), HW'(16'h8100));
        check("t2_tag_bytes", HW'({last_hdr[14*8 +: 8], last_hdr[15*8 +: 8],
                                   last_hdr[16*8 +: 8], last_hdr[17*8 +: 8]}), HW'(32'h0064_0800));

        // 3: 10-byte runt, then a 20-byte frame captured from byte 0.
        r0 = runt_seen;
        build_frame(10, 16'h0000, 8'h77);
        send_frame(10);
        build_frame(20, 16'h86DD, 8'h5A);
        send_frame(20);
        wait_idle();
        check("t3_runt_count", HW'(runt_seen - r0), HW'(1));
        check("t3_byte0", HW'(last_hdr[7:0]), HW'(8'h5A));

        // 4: 16-byte frame, tail of header zero-filled, no payload.
        p0 = pay_seen;
        build_frame(16, 16'h0806, 8'h21);
        send_frame(16);
        wait_idle();
        check("t4_no_payload", HW'(pay_seen - p0), HW'(0));
        check("t4_hdr16_17", HW'(last_hdr[16*8 +: 16]), HW'(0));
        check("t4_in_ready_back", HW'(bus.in_ready), HW'(1));

        // 5: slow ack and throttled payload consumer, two frames back to back.
        ack_delay = 5;
        toggle_ready = 1'b1;
        p0 = pay_seen;
        build_frame(64, 16'h0800, 8'h40);
        send_frame(64);
        build_frame(40, 16'h0800, 8'h90);
        send_frame(40);
        wait_idle();
        check("t5_payload_count", HW'(pay_seen - p0), HW'(46 + 22));
        toggle_ready = 1'b0;
        ack_delay = 0;

        // Ack held high across consecutive exactly-18-byte frames.
        ack_always = 1'b1;
        build_frame(18, 16'h0800, 8'hA0);
        send_frame(18);
        build_frame(18, 16'h0800, 8'hB3);
        send_frame(18);
        wait_idle();
        ack_always = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 6: reset after byte 7 of a frame, then a fresh 64-byte frame.
        build_frame(64, 16'h0800, 8'hC5);
        send_frame(8);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p0 = pay_seen;
        build_frame(64, 16'h0800, 8'h2E);
        send_frame(64);
        wait_idle();
        check("t6_payload_count", HW'(pay_seen - p0), HW'(46));
        check("t6_byte0", HW'(last_hdr[7:0]), HW'(8'h2E));

        check("model_events_drained", HW'(ev_q.size()), HW'(0));
        check("model_payload_drained", HW'(pay_q.size()), HW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
